// File: rtl/bram_capture_ctrl_if.sv
// rtl/bram_capture_ctrl_if.sv - switch, strobe and BRAM port bundle for the capture controller
interface bram_capture_ctrl_if #(
  parameter int NB_ADDR = 11
) ();
  logic               i_start;
  logic               i_read;
  logic               i_abort;
  logic               i_sample_valid;
  logic               o_write_enable;
  logic [NB_ADDR-1:0] o_write_addr;
  logic               o_read_enable;
  logic [NB_ADDR-1:0] o_read_addr;
  logic               o_read_valid;
  logic               o_read_last;
  logic               o_full;
  logic               o_busy;
  logic [1:0]         o_state;

  // Environment side: drives switches and the sample strobe, observes the BRAM controls
  modport master (
    output i_start, i_read, i_abort, i_sample_valid,
    input  o_write_enable, o_write_addr, o_read_enable, o_read_addr,
    input  o_read_valid, o_read_last, o_full, o_busy, o_state
  );

  // Controller side
  modport slave (
    input  i_start, i_read, i_abort, i_sample_valid,
    output o_write_enable, o_write_addr, o_read_enable, o_read_addr,
    output o_read_valid, o_read_last, o_full, o_busy, o_state
  );
endinterface

// File: rtl/bram_capture_ctrl.sv
// rtl/bram_capture_ctrl.sv - capture/readout sequencer for one simple dual-port BRAM buffer
module bram_capture_ctrl #(
  parameter int NB_ADDR      = 11,
  parameter int CAPTURE_LEN  = 2048,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  i_reset,
  bram_capture_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2,
    READOUT = 2'd3
  } state_t;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(CAPTURE_LEN - 1);

  state_t                  state;
  logic [NB_ADDR-1:0]      wr_cnt;
  logic [NB_ADDR-1:0]      rd_cnt;
  logic                    full_q;
  logic                    start_d;
  logic                    read_d;
  logic                    start_p;
  logic                    read_p;
  logic [READ_LATENCY-1:0] valid_pipe;
  logic [READ_LATENCY-1:0] last_pipe;

  assign start_p = bus.i_start & ~start_d;
  assign read_p  = bus.i_read & ~read_d;

  // Switch history; reset high so a switch held through reset needs a release and re-press
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      start_d <= 1'b1;
      read_d  <= 1'b1;
    end else begin
      start_d <= bus.i_start;
      read_d  <= bus.i_read;
    end
  end

  // Main sequencer: abort wins over everything, start wins over read in FULL
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      wr_cnt <= '0;
      rd_cnt <= '0;
      full_q <= 1'b0;
    end else if (bus.i_abort) begin
      state  <= IDLE;
      wr_cnt <= '0;
      rd_cnt <= '0;
      full_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_p) begin
            state  <= CAPTURE;
            wr_cnt <= '0;
          end
        end
        CAPTURE: begin
          if (bus.i_sample_valid) begin
            if (wr_cnt == LAST_ADDR) begin
              state  <= FULL;
              wr_cnt <= '0;
              full_q <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (start_p) begin
            state  <= CAPTURE;
            wr_cnt <= '0;
            full_q <= 1'b0;
          end else if (read_p) begin
            state  <= READOUT;
            rd_cnt <= '0;
          end
        end
        READOUT: begin
          if (rd_cnt == LAST_ADDR) begin
            state  <= FULL;
            rd_cnt <= '0;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-side delay line matching the BRAM latency; flushed by abort
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      valid_pipe <= '0;
      last_pipe  <= '0;
    end else if (bus.i_abort) begin
      valid_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      valid_pipe[0] <= (state == READOUT);
      last_pipe[0]  <= (state == READOUT) && (rd_cnt == LAST_ADDR);
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
    end
  end

  assign bus.o_write_enable = (state == CAPTURE) & bus.i_sample_valid;
  assign bus.o_write_addr   = wr_cnt;
  assign bus.o_read_enable  = (state == READOUT);
  assign bus.o_read_addr    = rd_cnt;
  assign bus.o_read_valid   = valid_pipe[READ_LATENCY-1];
  assign bus.o_read_last    = last_pipe[READ_LATENCY-1];
  assign bus.o_full         = full_q;
  assign bus.o_busy         = (state == CAPTURE) | (state == READOUT);
  assign bus.o_state        = state;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// tb/tb_bram_capture_ctrl.sv - scoreboard bench for bram_capture_ctrl
module tb_bram_capture_ctrl;
  localparam int NB_ADDR = 3;
  localparam int LEN     = 8;
  localparam int LAT     = 2;
  localparam int S_IDLE = 0, S_CAP = 1, S_FULL = 2, S_READ = 3;

  logic clock   = 1'b0;
  logic i_reset = 1'b1;
  always #5 clock = ~clock;

  bram_capture_ctrl_if #(.NB_ADDR(NB_ADDR)) bus ();

  bram_capture_ctrl #(
    .NB_ADDR(NB_ADDR), .CAPTURE_LEN(LEN), .READ_LATENCY(LAT)
  ) dut (
    .clock(clock), .i_reset(i_reset), .bus(bus)
  );

  typedef struct {int cyc; int addr; int last;} ev_t;
  typedef struct {int state; int full; int re; int raddr;} st_t;

  ev_t wr_q[$];
  ev_t rd_q[$];
  st_t st_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  int m_state, m_wr, m_rd, m_full;
  bit m_sd, m_rdd;
  bit cur_st, cur_rd;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_wr = 0; m_rd = 0; m_full = 0;
    m_sd = 1'b1; m_rdd = 1'b1;
    wr_q.delete(); rd_q.delete(); st_q.delete();
  endtask

  // Reference: what one clock cycle should look like given the applied inputs
  task automatic model_cycle(input bit st, input bit rd, input bit ab, input bit sv);
    bit sp, rp;
    ev_t keep[$];
    sp = st && !m_sd;
    rp = rd && !m_rdd;
    m_sd = st;
    m_rdd = rd;
    st_q.push_back('{m_state, m_full, int'(m_state == S_READ), m_rd});
    if (m_state == S_CAP && sv) wr_q.push_back('{cyc, m_wr, 0});
    if (m_state == S_READ) rd_q.push_back('{cyc + LAT, m_rd, int'(m_rd == LEN - 1)});
    if (ab) begin
      foreach (rd_q[i]) if (rd_q[i].cyc <= cyc) keep.push_back(rd_q[i]);
      rd_q = keep;
      m_state = S_IDLE; m_wr = 0; m_rd = 0; m_full = 0;
    end else begin
      case (m_state)
        S_IDLE: if (sp) begin m_state = S_CAP; m_wr = 0; end
        S_CAP: if (sv) begin
          if (m_wr == LEN - 1) begin m_state = S_FULL; m_wr = 0; m_full = 1; end
          else m_wr++;
        end
        S_FULL: begin
          if (sp) begin m_state = S_CAP; m_wr = 0; m_full = 0; end
          else if (rp) begin m_state = S_READ; m_rd = 0; end
        end
        default: begin
          if (m_rd == LEN - 1) begin m_state = S_FULL; m_rd = 0; end
          else m_rd++;
        end
      endcase
    end
  endtask

  task automatic step(input bit st, input bit rd, input bit ab, input bit sv);
    @(negedge clock);
    cyc++;
    bus.i_start = st; bus.i_read = rd; bus.i_abort = ab; bus.i_sample_valid = sv;
    #1;
    model_cycle(st, rd, ab, sv);
  endtask

  task automatic run_to_full();
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 200 && m_state != S_FULL; k++) step(1, 0, 0, 1'($urandom % 2));
    chk("full_timeout", m_state, S_FULL);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, bus.o_state, 0);
    chk({tag, "_full"}, bus.o_full, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_we"}, bus.o_write_enable, 0);
    chk({tag, "_waddr"}, bus.o_write_addr, 0);
    chk({tag, "_re"}, bus.o_read_enable, 0);
    chk({tag, "_raddr"}, bus.o_read_addr, 0);
    chk({tag, "_rvalid"}, bus.o_read_valid, 0);
    chk({tag, "_rlast"}, bus.o_read_last, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents status, writes or read data
  initial begin
    st_t e;
    ev_t w;
    forever begin
      @(negedge clock);
      #3;
      if (mon_en) begin
        if (st_q.size() > 0) begin
          e = st_q.pop_front();
          chk("state", bus.o_state, e.state);
          chk("full", bus.o_full, e.full);
          chk("busy", bus.o_busy, int'(e.state == S_CAP || e.state == S_READ));
          chk("read_enable", bus.o_read_enable, e.re);
          if (e.re != 0) chk("read_addr", bus.o_read_addr, e.raddr);
        end
        if (bus.o_write_enable) begin
          if (wr_q.size() == 0) chk("write_unexpected", 1, 0);
          else begin
            w = wr_q.pop_front();
            chk("write_addr", bus.o_write_addr, w.addr);
            chk("write_cycle", cyc, w.cyc);
          end
        end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
          chk("write_missing", 0, 1);
          void'(wr_q.pop_front());
        end
        if (bus.o_read_valid) begin
          if (rd_q.size() == 0) chk("read_valid_unexpected", 1, 0);
          else begin
            w = rd_q.pop_front();
            chk("read_valid_cycle", cyc, w.cyc);
            chk("read_last", bus.o_read_last, w.last);
          end
        end else begin
          chk("read_last_idle", bus.o_read_last, 0);
          if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
            chk("read_valid_missing", 0, 1);
            void'(rd_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    bus.i_start = 1'b1; bus.i_read = 1'b0; bus.i_abort = 1'b0; bus.i_sample_valid = 1'b0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clock);
    i_reset = 1'b0;
    mon_en  = 1'b1;

    // T1: switch held through reset must not start a capture
    repeat (4) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    // T2: sample every second cycle
    for (int i = 0; i < 16; i++) step(1, 0, 0, 1'(i % 2));
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // T3: readout
    step(0, 1, 0, 0);
    repeat (12) step(0, 1, 0, 0);

    // T4: simultaneous start and read edges in FULL
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int k = 0; k < 50 && m_state != S_FULL; k++) step(1, 1, 0, 1);

    // T5: abort at write address 3, then abort mid-readout
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 50 && m_wr != 3; k++) step(1, 0, 0, 1);
    step(1, 0, 1, 0);
    repeat (3) step(1, 0, 0, 0);
    run_to_full();
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    repeat (5) step(0, 1, 0, 0);

    // Randomized traffic
    cur_st = 1'b0; cur_rd = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 8 == 0) cur_st = ~cur_st;
      if ($urandom % 6 == 0) cur_rd = ~cur_rd;
      step(cur_st, cur_rd, 1'($urandom % 60 == 0), 1'($urandom % 2));
    end
    step(0, 0, 1, 0);
    repeat (LAT + 2) step(0, 0, 0, 0);
    chk("write_queue_drained", wr_q.size(), 0);
    chk("read_queue_drained", rd_q.size(), 0);

    // T6: asynchronous reset in the middle of a readout
    run_to_full();
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    @(negedge clock);
    mon_en = 1'b0;
    bus.i_start = 1'b0; bus.i_read = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    @(negedge clock);
    i_reset = 1'b0;
    mon_en  = 1'b1;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 1);
    step(0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0);
    @(negedge clock);
    #5;
    chk("final_write_queue", wr_q.size(), 0);
    chk("final_read_queue", rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
